// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
// Turns a signed speed command into a rate-limited duty magnitude plus a
// direction bit for the PWM generator. A reversal always ramps down to zero,
// holds zero for a dead time, and only then flips direction. estop forces
// duty to zero and parks the block until the next command.
//
// Ports:
//   CLK100MHZ  in   system clock
//   rst        in   synchronous active-low reset
//   cmd_valid  in   one-cycle strobe that loads cmd_speed
//   cmd_speed  in   signed speed command (two's complement)
//   estop      in   level, forces duty to 0 while high
//   duty       out  unsigned duty magnitude
//   dir        out  1 = forward, 0 = reverse
//   duty_upd   out  one-cycle pulse alongside any new duty/dir value
//   busy       out  high whenever the sequencer is not in HOLD
module pwm_ramp_ctrl #(
  parameter logic [15:0] STEP     = 16'd1,
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned DEADTIME = 1000,
  parameter logic [15:0] MAX_DUTY = 16'd1000
) (
  input  logic        CLK100MHZ,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_speed,
  input  logic        estop,
  output logic [15:0] duty,
  output logic        dir,
  output logic        duty_upd,
  output logic        busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEADTIME + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME);
  localparam logic [DW-1:0] DEAD_ONE  = DW'(1);
  localparam logic [DW-1:0] DEAD_ZERO = DW'(0);

  localparam logic [1:0] HOLD     = 2'd0;
  localparam logic [1:0] RAMP     = 2'd1;
  localparam logic [1:0] REV_DOWN = 2'd2;
  localparam logic [1:0] DEAD     = 2'd3;

  logic [1:0]    state_r, state_nxt_s;
  logic [15:0]   duty_r, duty_nxt_s;
  logic          dir_r, dir_nxt_s;
  logic [15:0]   target_mag_r, target_mag_nxt_s;
  logic          target_dir_r, target_dir_nxt_s;
  logic [DW-1:0] dead_cnt_r, dead_cnt_nxt_s;
  logic [TW-1:0] tick_cnt_r;
  logic          tick_s;
  logic          duty_upd_r;
  logic          busy_r;
  logic [16:0]   cmd_abs_s;
  logic [15:0]   cmd_mag_s;
  logic          cmd_dir_s;
  logic [15:0]   ramp_step_s;
  logic [15:0]   down_step_s;

  // Move cur toward goal by STEP without overshooting; 17-bit math avoids wrap.
  function automatic logic [15:0] step_toward(input logic [15:0] cur, input logic [15:0] goal);
    logic [16:0] sum_v;
    logic [16:0] diff_v;
    sum_v  = {1'b0, cur} + {1'b0, STEP};
    diff_v = {1'b0, cur} - {1'b0, goal};
    if (cur < goal) begin
      step_toward = (sum_v > {1'b0, goal}) ? goal : sum_v[15:0];
    end else if (cur > goal) begin
      step_toward = (diff_v <= {1'b0, STEP}) ? goal : (cur - STEP);
    end else begin
      step_toward = cur;
    end
  endfunction

  // |-32768| needs the 17th bit, then saturate to MAX_DUTY.
  assign cmd_abs_s   = cmd_speed[15] ? (17'd0 - {cmd_speed[15], cmd_speed}) : {1'b0, cmd_speed};
  assign cmd_mag_s   = (cmd_abs_s > {1'b0, MAX_DUTY}) ? MAX_DUTY : cmd_abs_s[15:0];
  // A zero command keeps the present direction so it never triggers a reversal.
  assign cmd_dir_s   = (cmd_speed == 16'd0) ? dir_r : ~cmd_speed[15];
  assign tick_s      = (tick_cnt_r == TICK_LAST);
  assign ramp_step_s = step_toward(duty_r, target_mag_r);
  assign down_step_s = step_toward(duty_r, 16'd0);

  // Free-running ramp tick divider.
  always_ff @(posedge CLK100MHZ) begin
    if (!rst) begin
      tick_cnt_r <= TW'(0);
    end else if (tick_s) begin
      tick_cnt_r <= TW'(0);
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Next-state logic: estop first, then command capture and the sequencer.
  always_comb begin
    state_nxt_s      = state_r;
    duty_nxt_s       = duty_r;
    dir_nxt_s        = dir_r;
    target_mag_nxt_s = target_mag_r;
    target_dir_nxt_s = target_dir_r;
    dead_cnt_nxt_s   = dead_cnt_r;
    if (estop) begin
      // Aligning target_dir with dir keeps HOLD idle after release.
      duty_nxt_s       = 16'd0;
      target_mag_nxt_s = 16'd0;
      target_dir_nxt_s = dir_r;
      dead_cnt_nxt_s   = DEAD_ZERO;
      state_nxt_s      = HOLD;
    end else begin
      if (cmd_valid) begin
        target_mag_nxt_s = cmd_mag_s;
        target_dir_nxt_s = cmd_dir_s;
      end else begin
        target_mag_nxt_s = target_mag_r;
        target_dir_nxt_s = target_dir_r;
      end
      case (state_r)
        HOLD: begin
          if (target_dir_r != dir_r) begin
            if (duty_r != 16'd0) begin
              state_nxt_s = REV_DOWN;
            end else begin
              state_nxt_s    = DEAD;
              dead_cnt_nxt_s = DEAD_LOAD;
            end
          end else if (duty_r != target_mag_r) begin
            state_nxt_s = RAMP;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        RAMP: begin
          // No step is taken on the cycle a reversal is detected.
          if (target_dir_r != dir_r) begin
            if (duty_r != 16'd0) begin
              state_nxt_s = REV_DOWN;
            end else begin
              state_nxt_s    = DEAD;
              dead_cnt_nxt_s = DEAD_LOAD;
            end
          end else if (duty_r == target_mag_r) begin
            state_nxt_s = HOLD;
          end else if (tick_s) begin
            duty_nxt_s = ramp_step_s;
          end else begin
            duty_nxt_s = duty_r;
          end
        end
        REV_DOWN: begin
          if (target_dir_r == dir_r) begin
            state_nxt_s = RAMP;
          end else if (duty_r == 16'd0) begin
            state_nxt_s    = DEAD;
            dead_cnt_nxt_s = DEAD_LOAD;
          end else if (tick_s) begin
            duty_nxt_s = down_step_s;
            // Dead time starts on the same edge duty reaches zero.
            if (down_step_s == 16'd0) begin
              state_nxt_s    = DEAD;
              dead_cnt_nxt_s = DEAD_LOAD;
            end else begin
              state_nxt_s = REV_DOWN;
            end
          end else begin
            duty_nxt_s = duty_r;
          end
        end
        DEAD: begin
          duty_nxt_s = 16'd0;
          if (target_dir_r == dir_r) begin
            state_nxt_s    = RAMP;
            dead_cnt_nxt_s = DEAD_ZERO;
          end else if (dead_cnt_r <= DEAD_ONE) begin
            // Counter reaches zero on this edge: the only place dir flips.
            dir_nxt_s      = target_dir_r;
            state_nxt_s    = RAMP;
            dead_cnt_nxt_s = DEAD_ZERO;
          end else begin
            dead_cnt_nxt_s = dead_cnt_r - DEAD_ONE;
          end
        end
        default: begin
          state_nxt_s = HOLD;
          duty_nxt_s  = 16'd0;
        end
      endcase
    end
  end

  // State and output registers; duty_upd and busy are registered with the values they describe.
  always_ff @(posedge CLK100MHZ) begin
    if (!rst) begin
      state_r      <= HOLD;
      duty_r       <= 16'd0;
      dir_r        <= 1'b1;
      target_mag_r <= 16'd0;
      target_dir_r <= 1'b1;
      dead_cnt_r   <= DEAD_ZERO;
      duty_upd_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      duty_r       <= duty_nxt_s;
      dir_r        <= dir_nxt_s;
      target_mag_r <= target_mag_nxt_s;
      target_dir_r <= target_dir_nxt_s;
      dead_cnt_r   <= dead_cnt_nxt_s;
      duty_upd_r   <= (duty_nxt_s != duty_r) || (dir_nxt_s != dir_r);
      busy_r       <= (state_nxt_s != HOLD);
    end
  end

  assign duty     = duty_r;
  assign dir      = dir_r;
  assign duty_upd = duty_upd_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl (STEP=100, TICK_DIV=4, DEADTIME=8,
// MAX_DUTY=1000). Each command pushes the (duty, dir) values it must
// produce onto a queue; every duty_upd pulse pops and compares one entry.
module tb_pwm_ramp_ctrl;

  typedef struct {
    logic [15:0] duty;
    logic        dir;
  } ev_t;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [15:0] cmd_speed;
  logic        estop;
  logic [15:0] duty;
  logic        dir;
  logic        duty_upd;
  logic        busy;

  ev_t         exp_q[$];
  int          upd_hist[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  int          last_upd_cyc = 0;
  int          zero_cyc = 0;
  int          flip_cyc = 0;
  int          flip_cnt = 0;
  bit          mon_en = 1'b0;
  logic [15:0] prev_duty = 16'd0;
  logic        prev_dir = 1'b1;

  pwm_ramp_ctrl #(
    .STEP    (16'd100),
    .TICK_DIV(4),
    .DEADTIME(8),
    .MAX_DUTY(16'd1000)
  ) dut (
    .CLK100MHZ(clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_speed(cmd_speed),
    .estop    (estop),
    .duty     (duty),
    .dir      (dir),
    .duty_upd (duty_upd),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input int d, input logic dr);
    ev_t e;
    e.duty = 16'(d);
    e.dir  = dr;
    exp_q.push_back(e);
  endtask

  // Expected ramp from -> to in steps of 100, clamped at the goal.
  task automatic push_ramp(input int from, input int to, input logic dr);
    int v;
    v = from;
    while (v != to) begin
      if (v < to) v = (v + 100 > to) ? to : v + 100;
      else        v = (v - 100 < to) ? to : v - 100;
      push_ev(v, dr);
    end
  endtask

  // One clock; outputs sampled on the falling edge and checked against the scoreboard.
  task automatic cyc();
    ev_t e;
    @(negedge clk);
    cyc_n++;
    if (mon_en) begin
      chk("upd_pulse", {31'd0, duty_upd}, {31'd0, ((duty !== prev_duty) || (dir !== prev_dir))});
      if (dir !== prev_dir) begin
        chk("flip_at_zero_duty", {16'd0, duty}, 32'd0);
        flip_cyc = cyc_n;
        flip_cnt++;
      end else if (duty == 16'd0 && prev_duty != 16'd0) begin
        zero_cyc = cyc_n;
      end
      if (duty_upd === 1'b1) begin
        last_upd_cyc = cyc_n;
        upd_hist.push_back(cyc_n);
        chk("upd_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ev_duty", {16'd0, duty}, {16'd0, e.duty});
          chk("ev_dir", {31'd0, dir}, {31'd0, e.dir});
        end
      end
      prev_duty = duty;
      prev_dir  = dir;
    end
  endtask

  task automatic send_cmd(input logic [15:0] s);
    cmd_valid = 1'b1;
    cmd_speed = s;
    cyc();
    cmd_valid = 1'b0;
  endtask

  // Run until every expected event is seen and (optionally) busy has dropped.
  task automatic wait_done(input string tag, input bit need_idle);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || (need_idle && busy !== 1'b0)) && k < 400) begin
      cyc();
      k++;
    end
    chk(tag, {31'd0, (k < 400)}, 32'd1);
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_speed = 16'd0;
    estop     = 1'b0;

    // 1. Reset
    repeat (3) cyc();
    chk("rst_outputs", {13'd0, duty, dir, busy, duty_upd}, {13'd0, 16'd0, 1'b1, 1'b0, 1'b0});
    rst = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle_after_rst", {13'd0, duty, dir, busy, duty_upd}, {13'd0, 16'd0, 1'b1, 1'b0, 1'b0});
    end

    // 2. Ramp up to 250
    upd_hist.delete();
    push_ramp(0, 250, 1'b1);
    send_cmd(16'd250);
    wait_done("ramp250_done", 1'b1);
    chk("ramp250_updates", upd_hist.size(), 32'd3);
    if (upd_hist.size() >= 3) begin
      chk("ramp250_gap1", upd_hist[1] - upd_hist[0], 32'd4);
      chk("ramp250_gap2", upd_hist[2] - upd_hist[1], 32'd4);
    end
    chk("busy_fall_delay", cyc_n - last_upd_cyc, 32'd1);
    chk("ramp250_duty", {16'd0, duty}, 32'd250);

    // 3. Saturation both ways
    push_ramp(250, 1000, 1'b1);
    send_cmd(16'h7FFF);
    wait_done("sat_pos_done", 1'b1);
    chk("sat_pos_duty", {16'd0, duty}, 32'd1000);
    push_ramp(1000, 0, 1'b1);
    push_ev(0, 1'b0);
    push_ramp(0, 1000, 1'b0);
    send_cmd(16'h8000);
    wait_done("sat_neg_done", 1'b1);
    chk("sat_neg_duty", {16'd0, duty}, 32'd1000);
    chk("sat_neg_dir", {31'd0, dir}, 32'd0);
    chk("sat_neg_deadtime", flip_cyc - zero_cyc, 32'd8);

    // 4. Reversal from 300 forward to -200
    push_ramp(1000, 0, 1'b0);
    push_ev(0, 1'b1);
    push_ramp(0, 300, 1'b1);
    send_cmd(16'd300);
    wait_done("to300_done", 1'b1);
    chk("to300_duty_dir", {15'd0, duty, dir}, {15'd0, 16'd300, 1'b1});
    push_ramp(300, 0, 1'b1);
    push_ev(0, 1'b0);
    push_ramp(0, 200, 1'b0);
    send_cmd(16'hFF38);
    wait_done("rev_done", 1'b1);
    chk("rev_deadtime", flip_cyc - zero_cyc, 32'd8);
    chk("rev_duty_dir", {15'd0, duty, dir}, {15'd0, 16'd200, 1'b0});

    // 5. Abort a reversal while in dead time
    push_ramp(200, 0, 1'b0);
    push_ev(0, 1'b1);
    push_ramp(0, 100, 1'b1);
    send_cmd(16'd100);
    wait_done("fwd100_done", 1'b1);
    push_ev(0, 1'b1);
    send_cmd(16'hFF9C);
    wait_done("abort_to_zero", 1'b0);
    repeat (2) cyc();
    chk("abort_in_dead_busy", {31'd0, busy}, 32'd1);
    begin
      int flips_before;
      flips_before = flip_cnt;
      push_ramp(0, 150, 1'b1);
      send_cmd(16'd150);
      wait_done("abort_done", 1'b1);
      chk("abort_no_flip", flip_cnt - flips_before, 32'd0);
    end
    chk("abort_duty_dir", {15'd0, duty, dir}, {15'd0, 16'd150, 1'b1});

    // 6. Estop at 500
    push_ramp(150, 500, 1'b1);
    send_cmd(16'd500);
    wait_done("to500_done", 1'b1);
    push_ev(0, 1'b1);
    estop = 1'b1;
    cyc();
    chk("estop_duty", {16'd0, duty}, 32'd0);
    chk("estop_dir", {31'd0, dir}, 32'd1);
    cmd_valid = 1'b1;
    cmd_speed = 16'hFD44;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    estop = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    chk("post_estop_idle", {14'd0, duty, dir, busy}, {14'd0, 16'd0, 1'b1, 1'b0});
    chk("post_estop_queue", exp_q.size(), 32'd0);
    push_ramp(0, 200, 1'b1);
    send_cmd(16'd200);
    wait_done("after_estop_done", 1'b1);
    chk("after_estop_duty", {15'd0, duty, dir}, {15'd0, 16'd200, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
